fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Parametrised instruction-fetch stage for the RV32I core: owns the PC, issues pipelined word requests to instruction memory over a valid/ready request channel, buffers in-order responses in a DEPTH-entry prefetch FIFO, and hands {pc, instr} pairs to decode over a valid/ready output channel. A redirect from branch/jump resolution flushes the buffer, restarts fetch at the target and discards stale in-flight responses. It replaces the free-running PC register, PC+4 adder, PC mux and fetch memory of the single-cycle top.

## Interface
- XLEN, 32, address/instruction width
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of two, ≥2
- RESET_PC, 0, PC loaded at reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock, synchronous and active-high
- imem_req_valid  out  1  request presented
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid; responses are in request order, one per accepted request, no earlier than the cycle after acceptance
- imem_rsp_data  in  XLEN  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch target; bits [1:0] forced to 0
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  XLEN  head instruction

## Operation
- State: fetch_pc, FIFO (pc+instr per entry, wr/rd pointers, count), outstanding counter (0..DEPTH), drop counter (0..DEPTH).
- Credit = DEPTH − count − outstanding. imem_req_valid = (credit > 0) && !redirect_valid. imem_req_addr = fetch_pc.
- Request accepted (valid&&ready): fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1; the request pc is pushed into a DEPTH-entry pc-tag queue (part of the FIFO entry allocation).
- Response: outstanding −= 1. If drop > 0: drop −= 1, data discarded. Else write {tag pc, data} into FIFO, count += 1.
- Pop when out_valid && out_ready; count −= 1. Push and pop in the same cycle leave count unchanged.
- Credit scheme guarantees the FIFO never overflows; no response is ever back-pressured.
- Redirect (highest priority): fetch_pc ← {redirect_pc[XLEN-1:2],2'b00}; FIFO and tag queue cleared; drop ← outstanding − (imem_rsp_valid ? 1 : 0) (a response arriving that cycle is discarded); outstanding updated normally. An out handshake in the redirect cycle counts as completed.
- Back-to-back redirects: each reloads fetch_pc and recomputes drop from current outstanding.

## Timing
- Reset values: fetch_pc = RESET_PC, count = outstanding = drop = 0, out_valid = 0, imem_req_valid = 1 in the first cycle after reset deassertion (req_addr = RESET_PC). Reset mid-operation abandons in-flight responses; memory side is reset by the same rst.
- out_valid/out_pc/out_instr are registered FIFO outputs: a response written in cycle t is visible at t+1.
- Fetch-to-output latency with zero-wait memory: request t, response t+1, out_valid t+2.
- Steady state with out_ready=1 and memory ready: one instruction per cycle.
- Redirect in cycle t: out_valid = 0 at t+1; first request to target at t+1.

## Structure
- Package fetch_pkg: XLEN default, RESET_PC default, INSTR_BYTES = 4, typedef of the {pc, instr} FIFO entry.
- One sub-module: sync_fifo (parametrised WIDTH, DEPTH, registered read port, count output, synchronous clear) used for the data FIFO; pc-tag queue uses a second instance.

## Test plan
- Reset, memory always ready, 1-cycle response, out_ready=1 → requests 0x0,0x4,0x8…; out_pc 0x0 at cycle 2, then one instruction per cycle.
- out_ready=0 held, DEPTH=4 → exactly 4 requests issued, count=4, imem_req_valid stays 0 until one pop, then exactly one new request.
- imem_req_ready low 3 cycles → imem_req_addr held at 0x8, fetch_pc unchanged, no duplicate or skipped address.
- 3 outstanding, redirect_valid with redirect_pc=0x103 → next request addr 0x100, 3 stale responses dropped, first out_pc=0x100 with matching instr.
- Redirect coincident with a response and an out handshake → that response dropped, drop=outstanding−1, FIFO empty next cycle.
- fetch_pc=0xFFFFFFFC accepted → next request addr 0x00000000; rst asserted mid-stream → next cycle out_valid=0, req addr=RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds the {pc, instr} prefetch entry layout.
package fetch_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bus: imem request/response, redirect, decode output.
// master = fetch stage, slave = memory/decode side.
interface fetch_prefetch_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    output out_valid, out_pc, out_instr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_pc, out_instr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_prefetch_sync_fifo.sv
// Small synchronous FIFO with clear and occupancy count.
// Head is read straight from registered storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL) || do_pop);
  assign data_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

  // Storage write; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; clear empties in one cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: PC, pipelined imem requests, prefetch FIFO.
// Redirect flushes the buffer and drops stale in-flight responses.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned    XLEN     = XLEN_DEF,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input logic            clk,
  input logic            rst,
  fetch_prefetch_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic [CW-1:0]   credit;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  logic [XLEN-1:0] tag_head;
  logic            tag_valid;
  logic [CW-1:0]   tag_cnt_unused;
  logic [1:0]      rpc_lo_unused;
  fetch_entry_t    wr_ent;
  fetch_entry_t    rd_ent;

  assign credit   = CW'(DEPTH) - count - outst_q;
  assign bus.imem_req_valid = (credit != '0) && !bus.redirect_valid;
  assign bus.imem_req_addr  = pc_q;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep = bus.imem_rsp_valid && (drop_q == '0)
                 && !bus.redirect_valid && tag_valid;
  assign pop      = bus.out_valid && bus.out_ready;
  assign rpc_lo_unused = bus.redirect_pc[1:0];

  assign wr_ent = '{pc: tag_head, instr: bus.imem_rsp_data};
  assign bus.out_pc    = rd_ent.pc;
  assign bus.out_instr = rd_ent.instr;

  // Next PC, in-flight count and stale-response drop count.
  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    outst_d = outst_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    if (req_fire) pc_d = pc_q + XLEN'(INSTR_BYTES);
    if (bus.redirect_valid) begin
      pc_d   = {bus.redirect_pc[XLEN-1:2], 2'b00};
      drop_d = outst_q - CW'(bus.imem_rsp_valid);
    end else if (bus.imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.redirect_valid),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (rsp_keep),
    .data_o  (tag_head),
    .valid_o (tag_valid),
    .count_o (tag_cnt_unused)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_data_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.redirect_valid),
    .push_i  (rsp_keep),
    .data_i  (wr_ent),
    .pop_i   (pop),
    .data_o  (rd_ent),
    .valid_o (bus.out_valid),
    .count_o (count)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: vector table, corner sequences, random
// traffic against an epoch-based reference of the fetch stream.
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_if #(.XLEN(32)) bus ();

  fetch_prefetch #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned ep;
    int unsigned rdy;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        rr;
    logic        orr;
    logic        rv;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] pc;
  } vec_t;

  mreq_t       mq[$];
  ent_t        fq[$];
  int unsigned epoch = 0;
  int unsigned cyc = 0;
  int          rsp_pct = 100;
  logic [31:0] exp_pc = 32'h0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic        s_rv, s_ov, s_fire, s_rsp;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] imem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check against the model, advance it.
  task automatic step(logic redir, logic [31:0] rpc);
    mreq_t hd;
    int    room;
    logic  exp_rv;
    @(negedge clk);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    s_rsp = (mq.size() > 0) && (mq[0].rdy <= cyc)
         && ($urandom_range(99) < rsp_pct);
    bus.imem_rsp_valid = s_rsp;
    bus.imem_rsp_data  = s_rsp ? imem_word(mq[0].addr) : $urandom;
    #1;
    s_rv    = bus.imem_req_valid;
    s_addr  = bus.imem_req_addr;
    s_ov    = bus.out_valid;
    s_pc    = bus.out_pc;
    s_instr = bus.out_instr;
    s_fire  = s_rv && bus.imem_req_ready;
    room    = DEPTH - fq.size() - mq.size();
    exp_rv  = (room > 0) && !redir;
    chk("m_req_valid", 32'(s_rv), 32'(exp_rv));
    if (exp_rv) chk("m_req_addr", s_addr, exp_pc);
    chk("m_out_valid", 32'(s_ov), 32'(fq.size() > 0));
    if (fq.size() > 0) begin
      chk("m_out_pc", s_pc, fq[0].pc);
      chk("m_out_instr", s_instr, fq[0].instr);
    end
    if (s_rsp) hd = mq.pop_front();
    if (redir) begin
      fq.delete();
      epoch++;
      exp_pc = {rpc[31:2], 2'b00};
    end else begin
      if (s_ov && bus.out_ready && fq.size() > 0) void'(fq.pop_front());
      if (s_rsp && hd.ep == epoch)
        fq.push_back('{pc: hd.addr, instr: imem_word(hd.addr)});
    end
    if (s_fire) begin
      mq.push_back('{addr: s_addr, ep: epoch, rdy: cyc + 1});
      exp_pc = exp_pc + 32'd4;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.out_ready      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    fq.delete();
    epoch++;
    exp_pc = RESET_PC_DEF;
  endtask

  // Step until out_valid is seen, bounded; s_pc/s_instr hold the head.
  task automatic wait_out(string nm);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 32'h0);
      if (s_ov) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  vec_t tbl[9];
  int   fires;

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_req_ready = 1'b0;
    bus.out_ready      = 1'b0;

    // rr, or | req_valid, req_addr, out_valid, out_pc
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC};

    do_reset();
    rsp_pct = 100;
    for (int i = 0; i < 9; i++) begin
      bus.imem_req_ready = tbl[i].rr;
      bus.out_ready      = tbl[i].orr;
      step(1'b0, 32'h0);
      chk("t_req_valid", 32'(s_rv), 32'(tbl[i].rv));
      chk("t_req_addr", s_addr, tbl[i].addr);
      chk("t_out_valid", 32'(s_ov), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk("t_out_pc", s_pc, tbl[i].pc);
        chk("t_out_instr", s_instr, imem_word(tbl[i].pc));
      end
    end

    // Decode stalled: credit caps the prefetch at DEPTH requests.
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0);
      fires += int'(s_fire);
    end
    chk("stall_fires", fires, DEPTH);
    chk("stall_req_valid", 32'(s_rv), 32'd0);
    chk("stall_out_valid", 32'(s_ov), 32'd1);
    bus.out_ready = 1'b1;
    step(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0);
      fires += int'(s_fire);
    end
    chk("stall_refill", fires, 1);

    // Redirect with three requests in flight.
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    rsp_pct = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0103);
    chk("redir_req_off", 32'(s_rv), 32'd0);
    rsp_pct = 100;
    step(1'b0, 32'h0);
    chk("redir_req_valid", 32'(s_rv), 32'd1);
    chk("redir_req_addr", s_addr, 32'h100);
    wait_out("redir_timeout");
    chk("redir_out_pc", s_pc, 32'h100);
    chk("redir_out_instr", s_instr, imem_word(32'h100));

    // Redirect coincident with a response and an out handshake.
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    rsp_pct = 100;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0200);
    chk("coinc_rsp", 32'(s_rsp), 32'd1);
    chk("coinc_ov", 32'(s_ov), 32'd1);
    step(1'b0, 32'h0);
    chk("coinc_flushed", 32'(s_ov), 32'd0);
    wait_out("coinc_timeout");
    chk("coinc_out_pc", s_pc, 32'h200);

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFF);
    step(1'b0, 32'h0);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0);
    chk("wrap_addr1", s_addr, 32'h0000_0000);
    wait_out("wrap_timeout0");
    chk("wrap_out0", s_pc, 32'hFFFF_FFFC);
    wait_out("wrap_timeout1");
    chk("wrap_out1", s_pc, 32'h0000_0000);

    // Reset in the middle of a busy stream.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    do_reset();
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    step(1'b0, 32'h0);
    chk("rst_out_valid", 32'(s_ov), 32'd0);
    chk("rst_req_valid", 32'(s_rv), 32'd1);
    chk("rst_req_addr", s_addr, RESET_PC_DEF);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic        r;
      logic [31:0] rpc;
      if (i % 250 == 0) rsp_pct = $urandom_range(100, 30);
      if ($urandom_range(999) < 3) begin
        do_reset();
      end else begin
        bus.imem_req_ready = ($urandom_range(3) != 0);
        bus.out_ready      = ($urandom_range(9) < 7);
        r   = ($urandom_range(99) < 4);
        rpc = $urandom_range(1) ? $urandom : 32'($urandom_range(255));
        step(r, rpc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
